// File: rtl/encoder_value_ctrl.sv
// encoder_value_ctrl
//   Turns one-cycle cw/ccw/prs pulses from the rotary encoder front end into a
//   bank of user-adjustable value registers. A two-state menu (SELECT/ADJUST)
//   first chooses a channel, then edits that channel's value.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   cw, ccw, prs  one-cycle detent / button pulses
//   mode          0 = SELECT, 1 = ADJUST
//   sel           currently selected channel
//   vals          all registers, channel i at [i*WIDTH +: WIDTH]
//   upd           one-cycle pulse: a value register changed
//   upd_idx       channel written, valid while upd = 1
//
// Optional feature: define ENC_CTRL_ACCEL_EN to add detent acceleration
// (parameters ACCEL_TICKS and ACCEL_STEP).

module encoder_value_ctrl #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned MIN_VAL       = 0,
    parameter int unsigned MAX_VAL       = 255,
    parameter int unsigned INIT_VAL      = 0,
    parameter int unsigned WRAP          = 0,
    parameter int unsigned TIMEOUT_TICKS = 50000000
`ifdef ENC_CTRL_ACCEL_EN
    ,
    parameter int unsigned ACCEL_TICKS   = 2000000,
    parameter int unsigned ACCEL_STEP    = 10
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cw,
    input  logic                          ccw,
    input  logic                          prs,
    output logic                          mode,
    output logic [$clog2(CHANNELS)-1:0]   sel,
    output logic [CHANNELS*WIDTH-1:0]     vals,
    output logic                          upd,
    output logic [$clog2(CHANNELS)-1:0]   upd_idx
);

    localparam int unsigned SW = $clog2(CHANNELS);

    // Two guard bits keep value +/- step free of overflow before clamping.
    typedef logic signed [WIDTH+1:0] arith_t;
    localparam arith_t MIN_S = arith_t'(MIN_VAL);
    localparam arith_t MAX_S = arith_t'(MAX_VAL);

    typedef enum logic {
        ST_SELECT = 1'b0,
        ST_ADJUST = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [WIDTH-1:0] vals_q [CHANNELS];
    logic [WIDTH-1:0] vals_d [CHANNELS];
    logic             upd_q, upd_d;
    logic [SW-1:0]    upd_idx_q, upd_idx_d;
    logic [31:0]      timer_q, timer_d;

    // prs wins over rotation; cw and ccw together cancel out.
    logic ev_prs, ev_cw, ev_ccw;
    assign ev_prs = prs;
    assign ev_cw  = cw & ~ccw & ~prs;
    assign ev_ccw = ccw & ~cw & ~prs;

    arith_t step;

`ifdef ENC_CTRL_ACCEL_EN
    logic [31:0] gap_q, gap_d;
    logic        prev_vld_q, prev_vld_d;
    logic        prev_dir_q, prev_dir_d;   // 1 = last detent was cw

    always_comb begin
        step = arith_t'(1);
        if (prev_vld_q && (prev_dir_q == ev_cw) && (gap_q < ACCEL_TICKS)) begin
            step = arith_t'(ACCEL_STEP);
        end
    end
`else
    assign step = arith_t'(1);
`endif

    arith_t           cur, sum;
    logic [WIDTH-1:0] new_val;

    always_comb begin
        cur = arith_t'({2'b00, vals_q[sel_q]});
        sum = ev_cw ? (cur + step) : (cur - step);
        if (sum > MAX_S) begin
            new_val = (WRAP != 0) ? WIDTH'(MIN_VAL) : WIDTH'(MAX_VAL);
        end else if (sum < MIN_S) begin
            new_val = (WRAP != 0) ? WIDTH'(MAX_VAL) : WIDTH'(MIN_VAL);
        end else begin
            new_val = sum[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        vals_d    = vals_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        timer_d   = '0;
`ifdef ENC_CTRL_ACCEL_EN
        gap_d      = (gap_q >= ACCEL_TICKS) ? gap_q : gap_q + 32'd1;
        prev_vld_d = prev_vld_q;
        prev_dir_d = prev_dir_q;
`endif
        unique case (state_q)
            ST_SELECT: begin
`ifdef ENC_CTRL_ACCEL_EN
                prev_vld_d = 1'b0;
`endif
                if (ev_prs) begin
                    state_d = ST_ADJUST;
                end else if (ev_cw) begin
                    sel_d = (sel_q == SW'(CHANNELS - 1)) ? '0 : sel_q + 1'b1;
                end else if (ev_ccw) begin
                    sel_d = (sel_q == '0) ? SW'(CHANNELS - 1) : sel_q - 1'b1;
                end
            end
            ST_ADJUST: begin
                timer_d = (ev_prs | ev_cw | ev_ccw) ? '0 : timer_q + 32'd1;
                if (ev_prs) begin
                    state_d = ST_SELECT;
`ifdef ENC_CTRL_ACCEL_EN
                    prev_vld_d = 1'b0;
`endif
                end else if (ev_cw | ev_ccw) begin
                    if (new_val != vals_q[sel_q]) begin
                        vals_d[sel_q] = new_val;
                        upd_d         = 1'b1;
                        upd_idx_d     = sel_q;
                    end
`ifdef ENC_CTRL_ACCEL_EN
                    gap_d      = '0;
                    prev_vld_d = 1'b1;
                    prev_dir_d = ev_cw;
`endif
                end else if ((TIMEOUT_TICKS != 0) && (timer_d == TIMEOUT_TICKS)) begin
                    state_d = ST_SELECT;
                    timer_d = '0;
`ifdef ENC_CTRL_ACCEL_EN
                    prev_vld_d = 1'b0;
`endif
                end
            end
            default: state_d = ST_SELECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SELECT;
            sel_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
            timer_q   <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                vals_q[i] <= WIDTH'(INIT_VAL);
            end
`ifdef ENC_CTRL_ACCEL_EN
            gap_q      <= '0;
            prev_vld_q <= 1'b0;
            prev_dir_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
            timer_q   <= timer_d;
            vals_q    <= vals_d;
`ifdef ENC_CTRL_ACCEL_EN
            gap_q      <= gap_d;
            prev_vld_q <= prev_vld_d;
            prev_dir_q <= prev_dir_d;
`endif
        end
    end

    always_comb begin
        vals = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            vals[i*WIDTH +: WIDTH] = vals_q[i];
        end
    end

    assign mode    = (state_q == ST_ADJUST);
    assign sel     = sel_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;

endmodule

// File: tb/tb_encoder_value_ctrl.sv
// Bench for encoder_value_ctrl. Instances:
//   dut0  WRAP=0, bounds 0..255, TIMEOUT_TICKS=100
//   dut1  WRAP=1, bounds 0..255, timeout disabled
//   dut2  WRAP=0, bounds 10..20, INIT 15, timeout disabled
//   dut3  (ENC_CTRL_ACCEL_EN only) ACCEL_TICKS=50, ACCEL_STEP=10

module tb_encoder_value_ctrl;

`ifdef ENC_CTRL_ACCEL_EN
    localparam int NDUT = 4;
`else
    localparam int NDUT = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cw_i   [NDUT];
    logic        ccw_i  [NDUT];
    logic        prs_i  [NDUT];
    logic        mode_o [NDUT];
    logic [1:0]  sel_o  [NDUT];
    logic [31:0] vals_o [NDUT];
    logic        upd_o  [NDUT];
    logic [1:0]  idx_o  [NDUT];

    encoder_value_ctrl #(.WRAP(0), .TIMEOUT_TICKS(100)
`ifdef ENC_CTRL_ACCEL_EN
        , .ACCEL_STEP(1)
`endif
    ) dut0 (
        .clk(clk), .rst(rst), .cw(cw_i[0]), .ccw(ccw_i[0]), .prs(prs_i[0]),
        .mode(mode_o[0]), .sel(sel_o[0]), .vals(vals_o[0]), .upd(upd_o[0]), .upd_idx(idx_o[0])
    );

    encoder_value_ctrl #(.WRAP(1), .TIMEOUT_TICKS(0)
`ifdef ENC_CTRL_ACCEL_EN
        , .ACCEL_STEP(1)
`endif
    ) dut1 (
        .clk(clk), .rst(rst), .cw(cw_i[1]), .ccw(ccw_i[1]), .prs(prs_i[1]),
        .mode(mode_o[1]), .sel(sel_o[1]), .vals(vals_o[1]), .upd(upd_o[1]), .upd_idx(idx_o[1])
    );

    encoder_value_ctrl #(.WRAP(0), .MIN_VAL(10), .MAX_VAL(20), .INIT_VAL(15), .TIMEOUT_TICKS(0)
`ifdef ENC_CTRL_ACCEL_EN
        , .ACCEL_STEP(1)
`endif
    ) dut2 (
        .clk(clk), .rst(rst), .cw(cw_i[2]), .ccw(ccw_i[2]), .prs(prs_i[2]),
        .mode(mode_o[2]), .sel(sel_o[2]), .vals(vals_o[2]), .upd(upd_o[2]), .upd_idx(idx_o[2])
    );

`ifdef ENC_CTRL_ACCEL_EN
    encoder_value_ctrl #(.WRAP(0), .TIMEOUT_TICKS(0), .ACCEL_TICKS(50), .ACCEL_STEP(10)) dut3 (
        .clk(clk), .rst(rst), .cw(cw_i[3]), .ccw(ccw_i[3]), .prs(prs_i[3]),
        .mode(mode_o[3]), .sel(sel_o[3]), .vals(vals_o[3]), .upd(upd_o[3]), .upd_idx(idx_o[3])
    );
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          d;
        bit          c, cc, p;
        bit          m;
        logic [1:0]  s;
        logic [31:0] v;
        bit          u;
        logic [1:0]  ix;
    } vec_t;

    vec_t vt[$];

    task automatic add(input int d, input bit c, input bit cc, input bit p, input bit m,
                       input logic [1:0] s, input logic [31:0] v, input bit u, input logic [1:0] ix);
        vec_t e;
        e.d = d; e.c = c; e.cc = cc; e.p = p;
        e.m = m; e.s = s; e.v = v; e.u = u; e.ix = ix;
        vt.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int d, input bit c, input bit cc, input bit p);
        cw_i[d] = c; ccw_i[d] = cc; prs_i[d] = p;
        tick();
        cw_i[d] = 1'b0; ccw_i[d] = 1'b0; prs_i[d] = 1'b0;
    endtask

    task automatic idle(input int d, input int n);
        for (int k = 0; k < n; k++) apply(d, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            cw_i[i] = 1'b0; ccw_i[i] = 1'b0; prs_i[i] = 1'b0;
        end
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("rst%0d_mode", i), 32'(mode_o[i]), 32'd0);
            chk($sformatf("rst%0d_sel", i),  32'(sel_o[i]),  32'd0);
            chk($sformatf("rst%0d_vals", i), vals_o[i], (i == 2) ? 32'h0F0F0F0F : 32'h0);
            chk($sformatf("rst%0d_upd", i),  32'(upd_o[i]),  32'd0);
            chk($sformatf("rst%0d_idx", i),  32'(idx_o[i]),  32'd0);
        end

        // dut0: select wrap, edit ch0, qualification, saturate at 0.
        add(0, 1,0,0, 0, 2'd1, 32'h0,   0, 2'd0);
        add(0, 1,0,0, 0, 2'd2, 32'h0,   0, 2'd0);
        add(0, 1,0,0, 0, 2'd3, 32'h0,   0, 2'd0);
        add(0, 1,0,0, 0, 2'd0, 32'h0,   0, 2'd0);
        add(0, 0,1,0, 0, 2'd3, 32'h0,   0, 2'd0);
        add(0, 1,0,0, 0, 2'd0, 32'h0,   0, 2'd0);
        add(0, 1,1,0, 0, 2'd0, 32'h0,   0, 2'd0);
        add(0, 0,0,1, 1, 2'd0, 32'h0,   0, 2'd0);
        add(0, 1,0,0, 1, 2'd0, 32'h1,   1, 2'd0);
        add(0, 0,0,0, 1, 2'd0, 32'h1,   0, 2'd0);
        add(0, 1,0,0, 1, 2'd0, 32'h2,   1, 2'd0);
        add(0, 1,0,0, 1, 2'd0, 32'h3,   1, 2'd0);
        add(0, 1,0,0, 1, 2'd0, 32'h4,   1, 2'd0);
        add(0, 1,0,0, 1, 2'd0, 32'h5,   1, 2'd0);
        add(0, 0,1,0, 1, 2'd0, 32'h4,   1, 2'd0);
        add(0, 1,1,0, 1, 2'd0, 32'h4,   0, 2'd0);
        add(0, 1,0,1, 0, 2'd0, 32'h4,   0, 2'd0);
        add(0, 1,0,0, 0, 2'd1, 32'h4,   0, 2'd0);
        add(0, 0,1,1, 1, 2'd1, 32'h4,   0, 2'd0);
        add(0, 0,1,0, 1, 2'd1, 32'h4,   0, 2'd0);
        add(0, 1,0,0, 1, 2'd1, 32'h104, 1, 2'd1);
        add(0, 0,0,1, 0, 2'd1, 32'h104, 0, 2'd0);
        // dut1: wrap at 0/255, edit ch3.
        add(1, 0,0,1, 1, 2'd0, 32'h0,        0, 2'd0);
        add(1, 0,1,0, 1, 2'd0, 32'hFF,       1, 2'd0);
        add(1, 1,0,0, 1, 2'd0, 32'h0,        1, 2'd0);
        add(1, 0,1,0, 1, 2'd0, 32'hFF,       1, 2'd0);
        add(1, 0,0,1, 0, 2'd0, 32'hFF,       0, 2'd0);
        add(1, 0,1,0, 0, 2'd3, 32'hFF,       0, 2'd0);
        add(1, 0,0,1, 1, 2'd3, 32'hFF,       0, 2'd0);
        add(1, 1,0,0, 1, 2'd3, 32'h010000FF, 1, 2'd3);

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i].d, vt[i].c, vt[i].cc, vt[i].p);
            chk($sformatf("v%0d_mode", i), 32'(mode_o[vt[i].d]), 32'(vt[i].m));
            chk($sformatf("v%0d_sel", i),  32'(sel_o[vt[i].d]),  32'(vt[i].s));
            chk($sformatf("v%0d_vals", i), vals_o[vt[i].d],      vt[i].v);
            chk($sformatf("v%0d_upd", i),  32'(upd_o[vt[i].d]),  32'(vt[i].u));
            if (vt[i].u) chk($sformatf("v%0d_idx", i), 32'(idx_o[vt[i].d]), 32'(vt[i].ix));
        end

        // dut0 timeout: 100 idle clocks in ADJUST return to SELECT.
        apply(0, 0, 0, 1);
        chk("to_enter", 32'(mode_o[0]), 32'd1);
        idle(0, 99);
        chk("to_99", 32'(mode_o[0]), 32'd1);
        idle(0, 1);
        chk("to_100", 32'(mode_o[0]), 32'd0);
        // A cw at clock 60 restarts the idle count; timeout lands at clock 160.
        apply(0, 0, 0, 1);
        idle(0, 59);
        apply(0, 1, 0, 0);
        chk("to_cw_val", vals_o[0], 32'h204);
        chk("to_cw_upd", 32'(upd_o[0]), 32'd1);
        idle(0, 99);
        chk("to_159", 32'(mode_o[0]), 32'd1);
        idle(0, 1);
        chk("to_160", 32'(mode_o[0]), 32'd0);

        // dut2: clamp at custom bounds 10..20, no upd when saturated.
        apply(2, 0, 0, 1);
        for (int k = 16; k <= 20; k++) begin
            apply(2, 1, 0, 0);
            chk($sformatf("b_up%0d", k), 32'(vals_o[2][7:0]), 32'(k));
            chk($sformatf("b_up%0d_upd", k), 32'(upd_o[2]), 32'd1);
        end
        apply(2, 1, 0, 0);
        chk("b_max_val", 32'(vals_o[2][7:0]), 32'd20);
        chk("b_max_upd", 32'(upd_o[2]), 32'd0);
        for (int k = 19; k >= 10; k--) begin
            apply(2, 0, 1, 0);
            chk($sformatf("b_dn%0d", k), 32'(vals_o[2][7:0]), 32'(k));
        end
        apply(2, 0, 1, 0);
        chk("b_min_val", 32'(vals_o[2][7:0]), 32'd10);
        chk("b_min_upd", 32'(upd_o[2]), 32'd0);
        idle(2, 200);
        chk("b_no_timeout", 32'(mode_o[2]), 32'd1);

`ifdef ENC_CTRL_ACCEL_EN
        // dut3: acceleration within 50 clocks, reset on direction change.
        apply(3, 0, 0, 1);
        apply(3, 1, 0, 0);
        chk("acc_first", 32'(vals_o[3][7:0]), 32'd1);
        idle(3, 19);
        apply(3, 1, 0, 0);
        chk("acc_fast", 32'(vals_o[3][7:0]), 32'd11);
        apply(3, 0, 1, 0);
        chk("acc_dirchg", 32'(vals_o[3][7:0]), 32'd10);
        idle(3, 60);
        apply(3, 0, 1, 0);
        chk("acc_slow", 32'(vals_o[3][7:0]), 32'd9);
        apply(3, 0, 1, 0);
        chk("acc_clamp", 32'(vals_o[3][7:0]), 32'd0);
        chk("acc_clamp_upd", 32'(upd_o[3]), 32'd1);
        apply(3, 0, 0, 1);
        apply(3, 0, 0, 1);
        apply(3, 1, 0, 0);
        chk("acc_after_prs", 32'(vals_o[3][7:0]), 32'd1);
`endif

        // Reset mid-operation restores everything.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_mode", 32'(mode_o[2]), 32'd0);
        chk("rst2_vals", vals_o[2], 32'h0F0F0F0F);
        chk("rst0_vals_mid", vals_o[0], 32'h0);
        chk("rst1_sel_mid", 32'(sel_o[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
